// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_pkg
//  Description : Shared TMDS definitions: word width, the four control tokens
//                and the deserializer state encoding. The encode side reuses
//                the same token constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam int c_TMDS_WORD_W = 10;

    localparam logic [c_TMDS_WORD_W-1:0] c_CTRL0 = 10'b1101010100;
    localparam logic [c_TMDS_WORD_W-1:0] c_CTRL1 = 10'b0010101011;
    localparam logic [c_TMDS_WORD_W-1:0] c_CTRL2 = 10'b0101010100;
    localparam logic [c_TMDS_WORD_W-1:0] c_CTRL3 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } deser_state_t;

    // True when the word is any of the four control tokens.
    function automatic logic is_ctrl_token(input logic [c_TMDS_WORD_W-1:0] word);
        return (word == c_CTRL0) || (word == c_CTRL1) ||
               (word == c_CTRL2) || (word == c_CTRL3);
    endfunction

    // Index of the control token (0 when the word is not a token).
    function automatic logic [1:0] ctrl_token_index(input logic [c_TMDS_WORD_W-1:0] word);
        logic [1:0] idx;
        idx = 2'd0;
        if (word == c_CTRL1) idx = 2'd1;
        if (word == c_CTRL2) idx = 2'd2;
        if (word == c_CTRL3) idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_decoder_10b8b.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder_10b8b
//  Description : Purely combinational TMDS 10b->8b decode of one aligned word.
//                Flags control tokens and reports their index; otherwise
//                undoes the optional inversion and the XOR/XNOR chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder_10b8b
    import tmds_pkg::*;
(
    input  logic [c_TMDS_WORD_W-1:0] i_word,
    output logic                     o_is_ctrl,
    output logic [1:0]               o_ctrl_idx,
    output logic [7:0]               o_pix_data
);

    logic [7:0] w_q;

    // Undo inversion (bit 9) then the transition-minimising chain (bit 8 = XOR).
    always_comb begin
        o_is_ctrl  = is_ctrl_token(i_word);
        o_ctrl_idx = ctrl_token_index(i_word);
        w_q        = i_word[9] ? ~i_word[7:0] : i_word[7:0];
        o_pix_data = 8'd0;
        o_pix_data[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            o_pix_data[i] = (w_q[i] ^ w_q[i-1]) ^ ~i_word[8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmds_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_deserializer
//  Description : Bit-clock TMDS channel deserializer. Hunts for control tokens
//                to recover 10-bit alignment, confirms LOCK_COUNT aligned
//                tokens, then emits aligned words with a one-cycle strobe.
//                Optional macro TMDS_DESER_DECODE_EN adds registered 10b->8b
//                decode outputs (pix_data, ctrl, de).
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_deserializer
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 4
)
(
    input  logic                     fast_clk,
    input  logic                     rst,
    input  logic                     q_in_p,
    input  logic                     relock,
    output logic [c_TMDS_WORD_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     locked
`ifdef TMDS_DESER_DECODE_EN
    ,
    output logic [7:0]               pix_data,
    output logic [1:0]               ctrl,
    output logic                     de
`endif
);

    localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_COUNT);

    deser_state_t             r_state;
    deser_state_t             w_next_state;
    logic [c_TMDS_WORD_W-1:0] r_win;
    logic [3:0]               r_phase;
    logic [3:0]               w_next_phase;
    logic [3:0]               r_match_cnt;
    logic [3:0]               w_next_match_cnt;
    logic                     w_is_token;
    logic                     w_load_word;
    logic [c_TMDS_WORD_W-1:0] r_data_out;
    logic                     r_data_valid;
    logic                     r_locked;

    assign w_is_token = is_ctrl_token(r_win);
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign locked     = r_locked;

    // State, phase and token-count registers.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_phase     <= 4'd0;
            r_match_cnt <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_phase     <= w_next_phase;
            r_match_cnt <= w_next_match_cnt;
        end
    end

    // Next-state logic: hunt on every cycle, confirm/emit only at phase 0.
    always_comb begin
        w_next_state     = r_state;
        w_next_phase     = (r_phase == 4'd9) ? 4'd0 : r_phase + 4'd1;
        w_next_match_cnt = r_match_cnt;
        w_load_word      = 1'b0;
        case (r_state)
            ST_HUNT: begin
                w_next_phase = 4'd0;
                if (w_is_token) begin
                    w_next_phase     = 4'd1;
                    w_next_match_cnt = 4'd1;
                    w_next_state     = (c_LOCK_CNT == 4'd1) ? ST_LOCKED : ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (relock) begin
                    w_next_state     = ST_HUNT;
                    w_next_phase     = 4'd0;
                    w_next_match_cnt = 4'd0;
                end else if (r_phase == 4'd0) begin
                    if (w_is_token) begin
                        w_next_match_cnt = r_match_cnt + 4'd1;
                        if (r_match_cnt + 4'd1 == c_LOCK_CNT) begin
                            w_next_state = ST_LOCKED;
                        end
                    end else begin
                        w_next_state     = ST_HUNT;
                        w_next_phase     = 4'd0;
                        w_next_match_cnt = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (relock) begin
                    w_next_state     = ST_HUNT;
                    w_next_phase     = 4'd0;
                    w_next_match_cnt = 4'd0;
                end else if (r_phase == 4'd0) begin
                    w_load_word = 1'b1;
                end
            end
            default: begin
                w_next_state     = ST_HUNT;
                w_next_phase     = 4'd0;
                w_next_match_cnt = 4'd0;
            end
        endcase
    end

    // Serial shift window (newest bit at the top) and the aligned-word outputs.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_win        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_win        <= {q_in_p, r_win[c_TMDS_WORD_W-1:1]};
            r_data_valid <= w_load_word;
            r_locked     <= (w_next_state == ST_LOCKED);
            if (w_load_word) begin
                r_data_out <= r_win;
            end
        end
    end

`ifdef TMDS_DESER_DECODE_EN
    logic       w_dec_is_ctrl;
    logic [1:0] w_dec_ctrl_idx;
    logic [7:0] w_dec_pix;
    logic [7:0] r_pix_data;
    logic [1:0] r_ctrl;
    logic       r_de;

    tmds_decoder_10b8b u_dec (
        .i_word     (r_win),
        .o_is_ctrl  (w_dec_is_ctrl),
        .o_ctrl_idx (w_dec_ctrl_idx),
        .o_pix_data (w_dec_pix)
    );

    // Decode outputs update alongside data_valid; ctrl holds across data words.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_pix_data <= 8'd0;
            r_ctrl     <= 2'd0;
            r_de       <= 1'b0;
        end else if (w_load_word) begin
            if (w_dec_is_ctrl) begin
                r_pix_data <= 8'd0;
                r_ctrl     <= w_dec_ctrl_idx;
                r_de       <= 1'b0;
            end else begin
                r_pix_data <= w_dec_pix;
                r_de       <= 1'b1;
            end
        end
    end

    assign pix_data = r_pix_data;
    assign ctrl     = r_ctrl;
    assign de       = r_de;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tmds_deserializer
//  Description : Self-checking bench for tmds_deserializer. Builds bit-level
//                scenarios, predicts outputs from a stream-level model and
//                compares every cycle, plus directed timing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_deserializer;

    localparam int c_MAXN      = 4096;
    localparam int LOCK_COUNT  = 4;
    localparam logic [9:0] c_T0 = 10'b1101010100;
    localparam logic [9:0] c_T1 = 10'b0010101011;
    localparam logic [9:0] c_T2 = 10'b0101010100;
    localparam logic [9:0] c_T3 = 10'b1010101011;

    logic       fast_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       q_in_p   = 1'b0;
    logic       relock   = 1'b0;
    logic [9:0] data_out;
    logic       data_valid;
    logic       locked;
`ifdef TMDS_DESER_DECODE_EN
    logic [7:0] pix_data;
    logic [1:0] ctrl;
    logic       de;
`endif

    tmds_deserializer #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .q_in_p     (q_in_p),
        .relock     (relock),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked)
`ifdef TMDS_DESER_DECODE_EN
        ,
        .pix_data   (pix_data),
        .ctrl       (ctrl),
        .de         (de)
`endif
    );

    always #5 fast_clk = ~fast_clk;

    // Scenario stimulus, one entry per rising edge.
    logic       s_bit [c_MAXN];
    logic       s_rst [c_MAXN];
    logic       s_rel [c_MAXN];
    int         n_len;

    // Model predictions and DUT observations, indexed by edge.
    logic [9:0] x_win    [c_MAXN];
    logic       x_locked [c_MAXN];
    logic       x_valid  [c_MAXN];
    logic [9:0] x_data   [c_MAXN];
    logic [7:0] x_pix    [c_MAXN];
    logic [1:0] x_ctrl   [c_MAXN];
    logic       x_de     [c_MAXN];
    logic       o_locked [c_MAXN];
    logic       o_valid  [c_MAXN];
    logic [9:0] o_data   [c_MAXN];
    logic [7:0] o_pix    [c_MAXN];
    logic       o_de     [c_MAXN];

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_tok(input logic [9:0] w);
        return (w == c_T0) || (w == c_T1) || (w == c_T2) || (w == c_T3);
    endfunction

    function automatic logic [1:0] tok_idx(input logic [9:0] w);
        if (w == c_T1) return 2'd1;
        if (w == c_T2) return 2'd2;
        if (w == c_T3) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [7:0] ref_pix(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] p;
        q    = w[9] ? ~w[7:0] : w[7:0];
        p    = 8'd0;
        p[0] = q[0];
        for (int i = 1; i < 8; i++) p[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return p;
    endfunction

    task automatic add_cycle(input logic b, input logic r, input logic rl);
        s_bit[n_len] = b;
        s_rst[n_len] = r;
        s_rel[n_len] = rl;
        n_len++;
    endtask

    task automatic add_reset(input int cycles);
        for (int i = 0; i < cycles; i++) add_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    endtask

    task automatic add_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) add_cycle(w[i], 1'b0, 1'b0);
    endtask

    // Stream-level reference: a token seen at edge A fixes alignment, so words
    // are judged at edges A+10k; lock after LOCK_COUNT aligned tokens.
    task automatic compute_model();
        int         mode;   // 0 searching, 1 confirming, 2 aligned
        int         anchor;
        int         seen;
        logic [9:0] wb;
        logic [9:0] h_data;
        logic [7:0] h_pix;
        logic [1:0] h_ctrl;
        logic       h_de;
        mode = 0; anchor = 0; seen = 0;
        h_data = '0; h_pix = '0; h_ctrl = '0; h_de = 1'b0;
        for (int e = 0; e < n_len; e++) begin
            wb       = (e == 0) ? 10'd0 : x_win[e-1];
            x_win[e] = s_rst[e] ? 10'd0 : {s_bit[e], wb[9:1]};
            x_valid[e] = 1'b0;
            if (s_rst[e]) begin
                mode = 0; seen = 0;
                h_data = '0; h_pix = '0; h_ctrl = '0; h_de = 1'b0;
            end else if (mode != 0 && s_rel[e]) begin
                mode = 0; seen = 0;
            end else if (mode == 0) begin
                if (is_tok(wb)) begin
                    anchor = e - 1;
                    seen   = 1;
                    mode   = (seen >= LOCK_COUNT) ? 2 : 1;
                end
            end else if (((e - 1 - anchor) % 10) == 0) begin
                if (mode == 1) begin
                    if (is_tok(wb)) begin
                        seen++;
                        if (seen >= LOCK_COUNT) mode = 2;
                    end else begin
                        mode = 0; seen = 0;
                    end
                end else begin
                    x_valid[e] = 1'b1;
                    h_data     = wb;
                    if (is_tok(wb)) begin
                        h_de = 1'b0; h_ctrl = tok_idx(wb); h_pix = 8'd0;
                    end else begin
                        h_de = 1'b1; h_pix = ref_pix(wb);
                    end
                end
            end
            x_locked[e] = (mode == 2);
            x_data[e]   = h_data;
            x_pix[e]    = h_pix;
            x_ctrl[e]   = h_ctrl;
            x_de[e]     = h_de;
        end
    endtask

    task automatic run_seq(input string name);
        compute_model();
        for (int e = 0; e < n_len; e++) begin
            rst    = s_rst[e];
            q_in_p = s_bit[e];
            relock = s_rel[e];
            @(posedge fast_clk);
            #1;
            o_locked[e] = locked;
            o_valid[e]  = data_valid;
            o_data[e]   = data_out;
            check_eq($sformatf("%s locked @%0d", name, e), 32'(locked), 32'(x_locked[e]));
            check_eq($sformatf("%s data_valid @%0d", name, e), 32'(data_valid), 32'(x_valid[e]));
            check_eq($sformatf("%s data_out @%0d", name, e), 32'(data_out), 32'(x_data[e]));
`ifdef TMDS_DESER_DECODE_EN
            o_pix[e] = pix_data;
            o_de[e]  = de;
            check_eq($sformatf("%s pix_data @%0d", name, e), 32'(pix_data), 32'(x_pix[e]));
            check_eq($sformatf("%s ctrl @%0d", name, e), 32'(ctrl), 32'(x_ctrl[e]));
            check_eq($sformatf("%s de @%0d", name, e), 32'(de), 32'(x_de[e]));
`else
            o_pix[e] = 8'd0;
            o_de[e]  = 1'b0;
`endif
        end
    endtask

    function automatic int first_lock(input int from);
        for (int e = from; e < n_len; e++) if (o_locked[e]) return e;
        return -1;
    endfunction

    function automatic int count_valid(input int from, input int to);
        int c;
        c = 0;
        for (int e = from; e <= to && e < n_len; e++) if (o_valid[e]) c++;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c;
        logic [9:0] w;

        // Reset, then lock on CTRL0 after three garbage bits.
        n_len = 0;
        add_reset(3);
        add_cycle(1'b1, 1'b0, 1'b0); add_cycle(1'b1, 1'b0, 1'b0); add_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add_word(c_T0);
        for (int i = 0; i < 10; i++) add_cycle(1'b0, 1'b0, 1'b0);
        run_seq("lock");
        t = 15;
        check_eq("reset data_out", 32'(o_data[2]), 32'd0);
        check_eq("reset locked", 32'(o_locked[2]), 32'd0);
        check_eq("lock latency", 32'(first_lock(0) - t), 32'd31);
        check_eq("lock first valid", 32'(o_valid[t+41]), 32'd1);
        check_eq("lock first word", 32'(o_data[t+41]), 32'(c_T0));
        check_eq("lock second valid", 32'(o_valid[t+51]), 32'd1);
        check_eq("lock valid spacing", 32'(count_valid(t+42, t+50)), 32'd0);

        // Confirm break: two CTRL1 then a non-token at the aligned slot.
        n_len = 0;
        add_reset(3);
        add_word(c_T1); add_word(c_T1); add_word(10'h1F3);
        for (int i = 0; i < 30; i++) add_cycle(1'b0, 1'b0, 1'b0);
        run_seq("break");
        check_eq("break locked", 32'(first_lock(0)), 32'hFFFF_FFFF);
        check_eq("break valids", 32'(count_valid(0, n_len - 1)), 32'd0);

        // Pixel data after lock on CTRL2.
        n_len = 0;
        add_reset(3);
        for (int i = 0; i < 4; i++) add_word(c_T2);
        add_word(10'b0100000000); add_word(10'b1011111111); add_word(c_T3);
        for (int i = 0; i < 12; i++) add_cycle(1'b0, 1'b0, 1'b0);
        run_seq("pixel");
        t = 12;
        check_eq("pixel word0", 32'(o_data[t+41]), 32'(10'b0100000000));
        check_eq("pixel word1", 32'(o_data[t+51]), 32'(10'b1011111111));
`ifdef TMDS_DESER_DECODE_EN
        check_eq("pixel pix0", 32'(o_pix[t+41]), 32'h00);
        check_eq("pixel pix1", 32'(o_pix[t+51]), 32'hFE);
        check_eq("pixel de1", 32'(o_de[t+51]), 32'd1);
`endif

        // Relock at a phase-0 word; relock while hunting is ignored.
        n_len = 0;
        add_reset(3);
        for (int i = 0; i < 14; i++) add_word(c_T3);
        t = 12;
        s_rel[5]    = 1'b1;
        s_rel[t+51] = 1'b1;
        run_seq("relock");
        check_eq("relock locked before", 32'(o_locked[t+50]), 32'd1);
        check_eq("relock suppressed valid", 32'(o_valid[t+51]), 32'd0);
        check_eq("relock locked falls", 32'(o_locked[t+51]), 32'd0);
        check_eq("relock reacquire", 32'(first_lock(t+51)), 32'(t+91));

        // Reset mid-word while locked.
        n_len = 0;
        add_reset(3);
        for (int i = 0; i < 11; i++) add_word(c_T0);
        t = 12;
        s_rst[t+36] = 1'b1;
        run_seq("midreset");
        check_eq("midreset locked", 32'(o_locked[t+36]), 32'd0);
        check_eq("midreset no valid", 32'(count_valid(t+36, t+90)), 32'd0);
        check_eq("midreset next valid", 32'(o_valid[t+91]), 32'd1);

        // Randomised mix of tokens, data words, garbage and relock pulses.
        for (int r = 0; r < 3; r++) begin
            n_len = 0;
            add_reset(3);
            c = $urandom_range(0, 9);
            for (int i = 0; i < c; i++) add_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    case ($urandom_range(0, 3))
                        0: w = c_T0;
                        1: w = c_T1;
                        2: w = c_T2;
                        default: w = c_T3;
                    endcase
                end else begin
                    w = 10'($urandom);
                end
                add_word(w);
            end
            for (int e = 3; e < n_len; e++) if ($urandom_range(0, 199) == 0) s_rel[e] = 1'b1;
            run_seq($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_deserializer.md
# tmds_deserializer

Receive-side counterpart of the HDMI TMDS serializer. Runs entirely in the bit-clock domain and takes one TMDS channel's serial bit stream, LSB first, as the serializer emits it. It recovers 10-bit word alignment by hunting for TMDS control tokens during blanking, then delivers aligned 10-bit words with a one-cycle valid strobe. It sits between the differential input buffer and the per-channel 10b/8b decode in the HDMI capture path.

## Interface
- `LOCK_COUNT`, default 4: number of consecutive aligned control tokens needed to declare lock. Legal range is 1..15.
- `fast_clk` in 1: bit clock. Everything in the block is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `q_in_p` in 1: serial TMDS bit, already single-ended. Bit 0 of each word arrives first.
- `relock` in 1: one-cycle request to drop lock and re-hunt.
- `data_out` out 10: aligned raw TMDS word. Bit 0 is the first bit received.
- `data_valid` out 1: one-cycle pulse when `data_out` is updated.
- `locked` out 1: high while in the LOCKED state.

## Operation
- Shift window, updated every edge: `win <= {q_in_p, win[9:1]}`.
- Token match is a combinational compare of `win` against the four control tokens:
  - CTRL0 = `10'b1101010100`
  - CTRL1 = `10'b0010101011`
  - CTRL2 = `10'b0101010100`
  - CTRL3 = `10'b1010101011`
- `phase` is a 4-bit counter that runs mod 10. `phase == 0` means `win` holds an aligned word.
- State machine:
  - **HUNT**: compares `win` against the tokens on every cycle. On a match it sets `phase <= 1`, `match_cnt <= 1` and moves to CONFIRM. If `LOCK_COUNT == 1`, a match goes directly to LOCKED with `phase <= 1`.
  - **CONFIRM**: `phase` free-runs. At `phase == 0`:
    - token: `match_cnt` increments. When it reaches `LOCK_COUNT`, move to LOCKED.
    - non-token: return to HUNT with `match_cnt <= 0`.
  - **LOCKED**: `phase` free-runs. At `phase == 0` the block registers `data_out <= win` and `data_valid <= 1`. Every other cycle `data_valid` is 0 and `data_out` holds its value. Lock is never lost automatically; it only ends on `relock` or `rst`.
- `relock`, when sampled high in CONFIRM or LOCKED, moves to HUNT on the next edge. That edge also clears `match_cnt` and drives `locked` and `data_valid` to 0. `relock` in HUNT has no effect.
- Simultaneous events:
  - `rst` overrides `relock`.
  - `relock` overrides a `phase == 0` word in LOCKED: no `data_valid` is produced for that word.
- `locked` is a registered decode of the state. It rises on the same edge that enters LOCKED.

## Timing
- Reset values:
  - state HUNT
  - `win` = 0, `phase` = 0, `match_cnt` = 0
  - `data_out` = 0, `data_valid` = 0, `locked` = 0
- Reset taken in the middle of a word discards the partial word. Lock must be reacquired from scratch.
- Latency: the last bit of a word is sampled into `win` at edge E. `data_out` and `data_valid` update at edge E+1.
- In LOCKED, `data_valid` pulses exactly every 10 cycles.
- Lock time from the first full token in `win`: (`LOCK_COUNT` − 1) × 10 + 1 cycles.
- The block has no backpressure. The consumer must accept every pulse.

## Configuration
- `TMDS_DESER_DECODE_EN`
  - **Defined**: adds the outputs below, registered on the same edge as `data_valid`:
    - `pix_data[7:0]`
    - `ctrl[1:0]`
    - `de`
  - Decode rules:
    - Token word: `de = 0`, `ctrl` = token index, `pix_data = 0`.
    - Any other word: `de = 1` and `ctrl` holds its previous value. Compute `q = win[9] ? ~win[7:0] : win[7:0]`. Then `pix_data[0] = q[0]`, and for i = 1..7, `pix_data[i] = q[i] ^ q[i-1]`, inverted when `win[8] == 0`.
    - Reset value of all three decode outputs is 0.
  - **Undefined**: the decode ports and the decode logic are absent.

## Structure
- Shared package `tmds_pkg` holds:
  - the four control token constants
  - `TMDS_WORD_W = 10`
  - the deserializer state enum (HUNT, CONFIRM, LOCKED)
- The serializer's encode side reuses the same token constants.
- Sub-module `tmds_decoder_10b8b` is purely combinational and is instantiated only under `TMDS_DESER_DECODE_EN`.

## Test plan
- **Reset**: hold `rst` high for 3 cycles with random `q_in_p` → all outputs 0, `locked` = 0.
- **Lock**:
  - Stimulus: 3 garbage bits, then CTRL0 repeated 6 times, with `LOCK_COUNT` = 4.
  - Expected: `locked` rises 31 cycles after the first token completes in `win`.
  - Expected: after lock, `data_valid` pulses every 10 cycles with `data_out` = `10'b1101010100`.
- **Confirm break**: 2 CTRL1 tokens followed by `10'h1F3` → state returns to HUNT, `locked` stays 0, no `data_valid`.
- **Pixel data**: after lock, send `10'b0100000000` then `10'b1011111111` → `data_out` shows each word.
  - With `TMDS_DESER_DECODE_EN`: `pix_data` = `8'h00` then `8'hFE`, with `de` = 1.
- **Relock**: pulse `relock` in LOCKED on a `phase == 0` cycle → no `data_valid` for that word. `locked` falls on the next edge. Relock completes after 4 further tokens.
- **Reset mid-word**: assert `rst` in LOCKED at `phase == 5` → all state cleared, and the next `data_valid` appears only after a full reacquisition.
